// File: rtl/prog_loader_if.sv
// prog_loader_if: CPU instruction-fetch bus between the 8-bit CPU core and
// the program memory that serves it.
//   addr_bus [9:0] : program counter driven by the CPU (master)
//   data_bus [7:0] : opcode/operand byte returned by program memory (slave)
interface prog_loader_if;
  logic [9:0] addr_bus;
  logic [7:0] data_bus;

  modport master (output addr_bus, input data_bus);
  modport slave  (input addr_bus, output data_bus);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: receives a program image over an 8N1 UART line, stores it in
// a program RAM, and releases the CPU from reset once the image checksum
// verifies. It then serves instruction bytes asynchronously from that RAM.
//
// Frame: A5 | LEN_HI | LEN_LO | LEN data bytes | CSUM (sum of data mod 256)
//
// Ports:
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   uart_rx    : asynchronous serial input, idle high
//   bus        : CPU instruction bus (addr_bus in, data_bus out)
//   cpu_rst    : active-high reset to the CPU
//   loading    : high while a frame is being received
//   load_error : sticky error flag, cleared by the next SYNC byte
//   byte_count : data bytes written in the current frame
module prog_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int PROG_DEPTH   = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         uart_rx,
  prog_loader_if.slave bus,
  output logic         cpu_rst,
  output logic         loading,
  output logic         load_error,
  output logic [10:0]  byte_count
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int              AW        = $clog2(PROG_DEPTH);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]      SYNC      = 8'hA5;
  localparam logic [10:0]     MAX_LEN   = 11'(PROG_DEPTH);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CSUM   = 3'd4;
  localparam logic [2:0] ST_RUN    = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  // ---------------------------------------------------------------- UART RX
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_ferr_q, rx_ferr_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          // Line high again at mid-start-bit: a glitch, not a start bit.
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == FULL_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: begin
        if (rx_cnt_q == FULL_LAST) begin
          rx_state_d = RX_IDLE;
          rx_valid_d = rx_sync_q;
          rx_ferr_d  = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // ------------------------------------------------------------ Frame FSM
  logic [2:0]  state_q, state_d;
  logic [2:0]  len_hi_q, len_hi_d;
  logic [10:0] len_q, len_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  sum_q, sum_d;
  logic        sync_hit;
  logic [10:0] len_rx;

  assign sync_hit = rx_valid_q && (rx_shift_q == SYNC);
  assign len_rx   = {len_hi_q, rx_shift_q};

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    if (rx_ferr_q && state_q != ST_IDLE && state_q != ST_RUN) begin
      state_d = ST_ERROR;
    end else if (rx_valid_q) begin
      case (state_q)
        ST_LEN_HI: begin
          if (|rx_shift_q[7:3]) begin
            state_d = ST_ERROR;
          end else begin
            len_hi_d = rx_shift_q[2:0];
            state_d  = ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          len_d   = len_rx;
          state_d = (len_rx == '0 || len_rx > MAX_LEN) ? ST_ERROR : ST_DATA;
        end
        ST_DATA: begin
          cnt_d = cnt_q + 1'b1;
          sum_d = sum_q + rx_shift_q;
          if (cnt_d == len_q) state_d = ST_CSUM;
        end
        ST_CSUM: state_d = (rx_shift_q == sum_q) ? ST_RUN : ST_ERROR;
        default: begin
          // IDLE, RUN and ERROR all start a new frame on SYNC only.
          if (sync_hit) begin
            state_d = ST_LEN_HI;
            cnt_d   = '0;
            sum_d   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      len_hi_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
    end
  end

  // ---------------------------------------------------------- Program RAM
  logic [7:0] mem_q [PROG_DEPTH];
  logic       ram_we;

  assign ram_we = rst_n && rx_valid_q && (state_q == ST_DATA);

  // NOTE: the RAM has no reset branch; the image must survive rst_n.
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[cnt_q[AW-1:0]] <= rx_shift_q;
  end

  // -------------------------------------------------------------- Outputs
  // A SYNC byte in RUN takes the CPU back into reset in the same cycle it
  // arrives, ahead of the state register moving to LEN_HI.
  assign cpu_rst    = (state_q != ST_RUN) || sync_hit;
  assign loading    = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_CSUM)   ||
                      (state_q == ST_RUN && sync_hit);
  assign load_error = (state_q == ST_ERROR);
  assign byte_count = cnt_q;
  assign bus.data_bus = cpu_rst ? 8'h00 : mem_q[bus.addr_bus];

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream program-memory stage for the 8-bit CPU core.
- Receives a program image over a UART line and stores it in a 1024x8 program RAM.
- Holds the CPU in reset while loading. Once the image's checksum verifies, releases the CPU and serves opcode/operand bytes on the CPU's instruction bus from the CPU's 10-bit address.
- Replaces the external ROM on the CPU's data_bus.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per UART bit (>=4).
- PROG_DEPTH, 1024, program RAM depth in bytes (fixed by the 10-bit address).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- uart_rx  in  1  asynchronous serial input, 8N1, idle high.
- addr_bus  in  10  CPU program counter.
- data_bus  out  8  instruction byte to the CPU.
- cpu_rst  out  1  active-high reset to the CPU.
- loading  out  1  high while a frame is being received.
- load_error  out  1  sticky error flag.
- byte_count  out  11  data bytes written in the current frame.

Behaviour:
- Reset (rst_n=0 at posedge):
  - cpu_rst=1, loading=0, load_error=0, byte_count=0.
  - State=IDLE, UART receiver idle.
  - Program RAM contents are not cleared.
- Clock and reset: rst_n has no effect between edges.
- UART receiver:
  - uart_rx passes through a 2-flop synchroniser.
  - A start bit is detected on a high-to-low transition of the synchronised line.
  - The line is re-sampled CLKS_PER_BIT/2 cycles later. If it is high, the start is treated as a glitch and the receiver returns to idle.
  - 8 data bits are sampled LSB first, each CLKS_PER_BIT apart.
  - The stop bit is sampled next. If it is 1, rx_valid pulses for one cycle and the byte is delivered. If it is 0, a framing error is raised.
- Frame format:
  - Byte 0: SYNC = 0xA5.
  - Byte 1: LEN_HI. Bits [2:0] are used; bits [7:3] must be 0.
  - Byte 2: LEN_LO.
  - Then LEN data bytes, written to addresses 0..LEN-1.
  - Then CSUM = low 8 bits of the sum of all data bytes.
  - LEN = {LEN_HI[2:0], LEN_LO}. Valid range is 1..1024.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CSUM, RUN, ERROR.
- IDLE:
  - cpu_rst=1.
  - A byte equal to SYNC moves to LEN_HI, sets loading=1, clears load_error, byte_count, write pointer and checksum accumulator.
  - Other bytes are ignored.
- LEN_HI: any of bits [7:3] set -> ERROR. Otherwise -> LEN_LO.
- LEN_LO: LEN=0 or LEN>1024 -> ERROR. Otherwise -> DATA.
- DATA:
  - Each rx_valid writes the byte to RAM[ptr] in the same cycle, increments ptr and byte_count, and adds the byte to the accumulator (mod 256).
  - When byte_count reaches LEN -> CSUM.
- CSUM:
  - Match: next cycle loading=0, cpu_rst=0, state=RUN.
  - Mismatch -> ERROR.
- RUN:
  - cpu_rst=0.
  - A SYNC byte restarts the load: in the same cycle cpu_rst=1, loading=1, state=LEN_HI.
  - Non-SYNC bytes are ignored.
- ERROR:
  - cpu_rst=1, loading=0, load_error=1.
  - A SYNC byte leaves ERROR exactly as from IDLE.
- A framing error in any state other than IDLE/RUN -> ERROR. In IDLE/RUN it is ignored.
- data_bus:
  - Asynchronous read, data_bus = RAM[addr_bus], whenever cpu_rst=0.
  - data_bus = 0x00 whenever cpu_rst=1.
  - Addresses >= LEN return whatever was previously stored there.
- Write-read collision: not possible, because the CPU is in reset during any write.
- A rst_n assertion mid-frame aborts the frame. Bytes already written stay in RAM, and the CPU stays in reset until a new valid frame arrives.
- A frame longer than LEN, i.e. extra bytes after CSUM:
  - In RUN, they are ignored unless a byte equals SYNC.
  - In ERROR, they are ignored.

Test Plan (CLKS_PER_BIT=4):
- Reset, then send A5 00 03 11 22 33 66 -> loading high from the SYNC byte. byte_count reaches 3. cpu_rst falls 1 cycle after the CSUM stop bit. With addr_bus=0,1,2, data_bus=11,22,33.
- Send A5 00 02 10 20 31 (bad CSUM) -> load_error=1, cpu_rst stays 1, data_bus=00. Then send A5 00 01 7F 7F -> load_error clears, cpu_rst=0, RAM[0]=7F.
- Send A5 08 00 (length above 1024) and A5 00 00 (length 0) -> ERROR after LEN_HI and after LEN_LO respectively, cpu_rst=1.
- While in RUN, inject a stop bit of 0 on a non-SYNC byte -> ignored, cpu_rst stays 0. Then send A5 -> cpu_rst=1 the same cycle rx_valid fires.
- Glitch on uart_rx of 1 clk low while idle -> no byte delivered, state unchanged. Full 1024-byte frame (bytes = addr[7:0], CSUM = 0x00) -> RAM[3FF]=FF, RUN entered.
- Assert rst_n=0 in the middle of the DATA phase -> on the next edge cpu_rst=1, loading=0, byte_count=0, state=IDLE.
